// File: rtl/flash_programmer.sv
// Avalon-style byte-program / sector-erase engine for a parallel NOR flash.
// Issues the unlock command sequence with registered pin timing, then polls FL_RY.
module flash_programmer #(
    parameter int WE_PULSE_CYCLES   = 4,
    parameter int BUSY_DELAY_CYCLES = 8,
    parameter int TIMEOUT_CYCLES    = 2_500_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AVL_WRITE,
    input  logic        AVL_ERASE,
    input  logic [22:0] AVL_ADDR,
    input  logic [7:0]  AVL_WRITEDATA,
    output logic        AVL_WAITREQUEST,
    output logic        AVL_DONE,
    output logic        AVL_ERROR,
    input  logic        FL_RY,
    output logic [22:0] FL_ADDR,
    output logic [7:0]  FL_DQ_OUT,
    output logic        FL_DQ_OE,
    output logic        FL_CE_N,
    output logic        FL_OE_N,
    output logic        FL_WE_N,
    output logic        FL_RESET_N,
    output logic        FL_WP_N
);

    typedef enum logic [2:0] {
        IDLE, SETUP, WE_LOW, HOLD, BUSY_WAIT, POLL, DONE
    } state_t;

    localparam int CYC_MAX = (WE_PULSE_CYCLES > BUSY_DELAY_CYCLES) ? WE_PULSE_CYCLES
                                                                   : BUSY_DELAY_CYCLES;
    localparam int CW = $clog2(CYC_MAX + 1);
    localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WE_LAST   = CW'(WE_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_DELAY_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cyc_reg, cyc_next;
    logic [PW-1:0] poll_reg, poll_next;
    logic [2:0]    idx_reg, idx_next;
    logic          erase_reg, erase_next;
    logic [22:0]   addr_reg, addr_next;
    logic [7:0]    data_reg, data_next;
    logic          error_reg, error_next;
    logic [22:0]   fl_addr_reg, fl_addr_next;
    logic [7:0]    fl_dq_reg, fl_dq_next;
    logic          fl_we_n_reg, fl_ce_n_reg, fl_dq_oe_reg, done_reg;
    logic          bus_next;
    logic [2:0]    last_idx;

    // Command word {address, data} for bus cycle idx of the selected operation.
    function automatic logic [30:0] bus_word(input logic erase, input logic [2:0] idx,
                                             input logic [22:0] addr, input logic [7:0] data);
        logic [30:0] w;
        w = {addr, data};
        if (erase) begin
            case (idx)
                3'd0:    w = {23'h000AAA, 8'hAA};
                3'd1:    w = {23'h000555, 8'h55};
                3'd2:    w = {23'h000AAA, 8'h80};
                3'd3:    w = {23'h000AAA, 8'hAA};
                3'd4:    w = {23'h000555, 8'h55};
                default: w = {addr, 8'h30};
            endcase
        end else begin
            case (idx)
                3'd0:    w = {23'h000AAA, 8'hAA};
                3'd1:    w = {23'h000555, 8'h55};
                3'd2:    w = {23'h000AAA, 8'hA0};
                default: w = {addr, data};
            endcase
        end
        return w;
    endfunction

    assign last_idx = erase_reg ? 3'd5 : 3'd3;

    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg;
        poll_next    = poll_reg;
        idx_next     = idx_reg;
        erase_next   = erase_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        error_next   = error_reg;
        fl_addr_next = fl_addr_reg;
        fl_dq_next   = fl_dq_reg;

        case (state_reg)
            IDLE: begin
                if (AVL_ERASE || AVL_WRITE) begin
                    erase_next = AVL_ERASE;
                    addr_next  = AVL_ADDR;
                    data_next  = AVL_WRITEDATA;
                    error_next = 1'b0;
                    idx_next   = 3'd0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                cyc_next   = '0;
                state_next = WE_LOW;
            end
            WE_LOW: begin
                if (cyc_reg == WE_LAST) state_next = HOLD;
                else                    cyc_next   = cyc_reg + CW'(1);
            end
            HOLD: begin
                if (idx_reg == last_idx) begin
                    cyc_next   = '0;
                    state_next = BUSY_WAIT;
                end else begin
                    idx_next   = idx_reg + 3'd1;
                    state_next = SETUP;
                end
            end
            BUSY_WAIT: begin
                if (cyc_reg == BUSY_LAST) begin
                    poll_next  = '0;
                    state_next = POLL;
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            POLL: begin
                // Ready takes priority over a timeout landing on the same cycle.
                if (FL_RY) begin
                    state_next = DONE;
                end else if (poll_reg == POLL_LAST) begin
                    error_next = 1'b1;
                    state_next = DONE;
                end else begin
                    poll_next = poll_reg + PW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Pin registers are loaded from next-state so they line up with the state they describe.
        if (state_next == SETUP)
            {fl_addr_next, fl_dq_next} = bus_word(erase_next, idx_next, addr_next, data_next);
        bus_next = (state_next == SETUP) || (state_next == WE_LOW) || (state_next == HOLD);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= IDLE;
            cyc_reg      <= '0;
            poll_reg     <= '0;
            idx_reg      <= '0;
            erase_reg    <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            error_reg    <= 1'b0;
            fl_addr_reg  <= '0;
            fl_dq_reg    <= '0;
            fl_we_n_reg  <= 1'b1;
            fl_ce_n_reg  <= 1'b1;
            fl_dq_oe_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cyc_reg      <= cyc_next;
            poll_reg     <= poll_next;
            idx_reg      <= idx_next;
            erase_reg    <= erase_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            error_reg    <= error_next;
            fl_addr_reg  <= fl_addr_next;
            fl_dq_reg    <= fl_dq_next;
            fl_we_n_reg  <= (state_next != WE_LOW);
            fl_ce_n_reg  <= !bus_next;
            fl_dq_oe_reg <= bus_next;
            done_reg     <= (state_next == DONE);
        end
    end

    assign AVL_WAITREQUEST = (state_reg != IDLE);
    assign AVL_DONE        = done_reg;
    assign AVL_ERROR       = error_reg;
    assign FL_ADDR         = fl_addr_reg;
    assign FL_DQ_OUT       = fl_dq_reg;
    assign FL_DQ_OE        = fl_dq_oe_reg;
    assign FL_CE_N         = fl_ce_n_reg;
    assign FL_WE_N         = fl_we_n_reg;
    assign FL_OE_N         = 1'b1;
    assign FL_WP_N         = 1'b1;
    assign FL_RESET_N      = RESET;

endmodule

// File: tb/tb_flash_programmer.sv
// Directed bench for flash_programmer: command sequences, latency, polling timeout, reset abort.
// A second instance with a short timeout covers the error path.
module tb_flash_programmer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        AVL_WRITE, AVL_ERASE;
    logic [22:0] AVL_ADDR;
    logic [7:0]  AVL_WRITEDATA;
    logic        fl_ry, fl_ry_to;

    logic        m_wait, m_done, m_err, m_oe, m_ce_n, m_oe_n, m_we_n, m_rst_n, m_wp_n;
    logic [22:0] m_addr;
    logic [7:0]  m_dq;
    logic        t_wait, t_done, t_err, t_oe, t_ce_n, t_oe_n, t_we_n, t_rst_n, t_wp_n;
    logic [22:0] t_addr;
    logic [7:0]  t_dq;

    always #5 CLK = ~CLK;

    flash_programmer dut (
        .CLK(CLK), .RESET(RESET), .AVL_WRITE(AVL_WRITE), .AVL_ERASE(AVL_ERASE),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_WAITREQUEST(m_wait), .AVL_DONE(m_done), .AVL_ERROR(m_err),
        .FL_RY(fl_ry), .FL_ADDR(m_addr), .FL_DQ_OUT(m_dq), .FL_DQ_OE(m_oe),
        .FL_CE_N(m_ce_n), .FL_OE_N(m_oe_n), .FL_WE_N(m_we_n),
        .FL_RESET_N(m_rst_n), .FL_WP_N(m_wp_n)
    );

    flash_programmer #(.TIMEOUT_CYCLES(50)) dut_to (
        .CLK(CLK), .RESET(RESET), .AVL_WRITE(AVL_WRITE), .AVL_ERASE(AVL_ERASE),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_WAITREQUEST(t_wait), .AVL_DONE(t_done), .AVL_ERROR(t_err),
        .FL_RY(fl_ry_to), .FL_ADDR(t_addr), .FL_DQ_OUT(t_dq), .FL_DQ_OE(t_oe),
        .FL_CE_N(t_ce_n), .FL_OE_N(t_oe_n), .FL_WE_N(t_we_n),
        .FL_RESET_N(t_rst_n), .FL_WP_N(t_wp_n)
    );

    // Monitored instance selector
    bit          sel_to;
    logic        mon_wait, mon_done, mon_err, mon_oe, mon_ce_n, mon_we_n;
    logic [22:0] mon_addr;
    logic [7:0]  mon_dq;
    always_comb begin
        mon_wait = sel_to ? t_wait : m_wait;
        mon_done = sel_to ? t_done : m_done;
        mon_err  = sel_to ? t_err  : m_err;
        mon_oe   = sel_to ? t_oe   : m_oe;
        mon_ce_n = sel_to ? t_ce_n : m_ce_n;
        mon_we_n = sel_to ? t_we_n : m_we_n;
        mon_addr = sel_to ? t_addr : m_addr;
        mon_dq   = sel_to ? t_dq   : m_dq;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Captured WE pulses of the last operation
    logic [22:0] p_addr [16];
    logic [7:0]  p_data [16];
    int          p_width[16];
    bit          p_ok   [16];
    int          p_n;
    logic        k1_err;
    int          rise_k;
    int          busy_gap;

    typedef struct {
        bit              er;
        bit              wr;
        logic [22:0]     a;
        logic [7:0]      d;
        int              n;
        logic [5:0][22:0] ea;   // index 0 is the rightmost element of the concatenation
        logic [5:0][7:0]  ed;
        int              lat;
    } vec_t;
    vec_t vecs[5];

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (!m_wait && !t_wait) begin ok = 1; break; end
        end
        chk("wait_idle", 32'(ok), 32'd1);
    endtask

    task automatic issue(input bit er, input bit wr, input logic [22:0] a, input logic [7:0] d);
        @(negedge CLK);
        AVL_ERASE     = er;
        AVL_WRITE     = wr;
        AVL_ADDR      = a;
        AVL_WRITEDATA = d;
    endtask

    // Cycle k=1 is the first cycle after the accepting edge; returns the cycle AVL_DONE is seen.
    task automatic monitor(input bit hold_wr, input logic [22:0] ha, input logic [7:0] hd,
                           input int rise_after, input int rise_pulses, output int latency);
        int low = 0;
        int end_k = -1;
        latency  = -1;
        p_n      = 0;
        rise_k   = -1;
        busy_gap = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                k1_err    = mon_err;
                AVL_ERASE = 1'b0;
                AVL_WRITE = hold_wr;
                if (hold_wr) begin AVL_ADDR = ha; AVL_WRITEDATA = hd; end
            end
            if (mon_wait !== 1'b1) busy_gap++;
            if (p_n < 16) begin
                if (mon_we_n === 1'b0) begin
                    if (low == 0) begin
                        p_addr[p_n] = mon_addr; p_data[p_n] = mon_dq; p_ok[p_n] = 1;
                    end else if (mon_addr !== p_addr[p_n] || mon_dq !== p_data[p_n]) begin
                        p_ok[p_n] = 0;
                    end
                    if (mon_ce_n !== 1'b0 || mon_oe !== 1'b1) p_ok[p_n] = 0;
                    low++;
                end else if (low > 0) begin
                    if (mon_addr !== p_addr[p_n] || mon_dq !== p_data[p_n] ||
                        mon_ce_n !== 1'b0 || mon_oe !== 1'b1) p_ok[p_n] = 0;
                    p_width[p_n] = low;
                    p_n++;
                    low = 0;
                    if (p_n == rise_pulses) end_k = k;
                end
            end
            if (rise_after >= 0 && end_k >= 0 && k == end_k + rise_after) begin
                fl_ry  = 1'b1;
                rise_k = k;
            end
            if (mon_done === 1'b1) begin latency = k; break; end
        end
    endtask

    task automatic check_pulses(input string tag, input int n,
                                input logic [5:0][22:0] ea, input logic [5:0][7:0] ed);
        chk($sformatf("%s.pulses", tag), 32'(p_n), 32'(n));
        for (int i = 0; i < n && i < p_n; i++) begin
            chk($sformatf("%s.addr%0d", tag, i), 32'(p_addr[i]), 32'(ea[i]));
            chk($sformatf("%s.data%0d", tag, i), 32'(p_data[i]), 32'(ed[i]));
            chk($sformatf("%s.width%0d", tag, i), 32'(p_width[i]), 32'd4);
            chk($sformatf("%s.pins%0d", tag, i), 32'(p_ok[i]), 32'd1);
        end
    endtask

    // Called on the AVL_DONE cycle: checks the pulse is one cycle and the bus is parked.
    task automatic after_done(input string tag, input logic exp_err, input logic [22:0] last_addr);
        chk($sformatf("%s.err_at_done", tag), 32'(mon_err), 32'(exp_err));
        chk($sformatf("%s.busy_gap", tag), 32'(busy_gap), 32'd0);
        @(negedge CLK);
        chk($sformatf("%s.done_one_cycle", tag), 32'(mon_done), 32'd0);
        chk($sformatf("%s.idle_wait", tag), 32'(mon_wait), 32'd0);
        chk($sformatf("%s.idle_pins", tag), {29'd0, mon_we_n, mon_ce_n, mon_oe}, 32'b110);
        chk($sformatf("%s.idle_addr_hold", tag), 32'(mon_addr), 32'(last_addr));
        chk($sformatf("%s.err_sticky", tag), 32'(mon_err), 32'(exp_err));
    endtask

    initial begin
        int lat;
        bit found;
        int we_lows, wait_highs;

        vecs[0] = '{er:1'b0, wr:1'b1, a:23'h012345, d:8'h5A, n:4, lat:34,
                    ea:{23'h0, 23'h0, 23'h012345, 23'h000AAA, 23'h000555, 23'h000AAA},
                    ed:{8'h00, 8'h00, 8'h5A, 8'hA0, 8'h55, 8'hAA}};
        vecs[1] = '{er:1'b0, wr:1'b1, a:23'h000000, d:8'h00, n:4, lat:34,
                    ea:{23'h0, 23'h0, 23'h000000, 23'h000AAA, 23'h000555, 23'h000AAA},
                    ed:{8'h00, 8'h00, 8'h00, 8'hA0, 8'h55, 8'hAA}};
        vecs[2] = '{er:1'b0, wr:1'b1, a:23'h7FFFFF, d:8'hFF, n:4, lat:34,
                    ea:{23'h0, 23'h0, 23'h7FFFFF, 23'h000AAA, 23'h000555, 23'h000AAA},
                    ed:{8'h00, 8'h00, 8'hFF, 8'hA0, 8'h55, 8'hAA}};
        vecs[3] = '{er:1'b1, wr:1'b0, a:23'h7F0000, d:8'h00, n:6, lat:46,
                    ea:{23'h7F0000, 23'h000555, 23'h000AAA, 23'h000AAA, 23'h000555, 23'h000AAA},
                    ed:{8'h30, 8'h55, 8'hAA, 8'h80, 8'h55, 8'hAA}};
        vecs[4] = '{er:1'b1, wr:1'b0, a:23'h000123, d:8'h77, n:6, lat:46,
                    ea:{23'h000123, 23'h000555, 23'h000AAA, 23'h000AAA, 23'h000555, 23'h000AAA},
                    ed:{8'h30, 8'h55, 8'hAA, 8'h80, 8'h55, 8'hAA}};

        RESET = 1'b0; AVL_WRITE = 1'b0; AVL_ERASE = 1'b0;
        AVL_ADDR = '0; AVL_WRITEDATA = '0;
        fl_ry = 1'b1; fl_ry_to = 1'b1; sel_to = 0;

        // Reset values
        @(negedge CLK);
        chk("rst.we_n", 32'(m_we_n), 32'd1);
        chk("rst.ce_n", 32'(m_ce_n), 32'd1);
        chk("rst.dq_oe", 32'(m_oe), 32'd0);
        chk("rst.addr", 32'(m_addr), 32'd0);
        chk("rst.dq", 32'(m_dq), 32'd0);
        chk("rst.done_err_wait", {29'd0, m_done, m_err, m_wait}, 32'd0);
        chk("rst.reset_n", {30'd0, m_rst_n, t_rst_n}, 32'd0);
        chk("rst.oe_wp", {28'd0, m_oe_n, m_wp_n, t_oe_n, t_wp_n}, 32'hF);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("run.reset_n", 32'(m_rst_n), 32'd1);

        // Table-driven program/erase vectors, FL_RY ready
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            issue(vecs[i].er, vecs[i].wr, vecs[i].a, vecs[i].d);
            monitor(0, '0, '0, -1, 0, lat);
            chk($sformatf("v%0d.latency", i), 32'(lat), 32'(vecs[i].lat));
            check_pulses($sformatf("v%0d", i), vecs[i].n, vecs[i].ea, vecs[i].ed);
            after_done($sformatf("v%0d", i), 1'b0, vecs[i].a);
        end

        // Erase with FL_RY low for 100 cycles after the last WE pulse
        wait_idle();
        fl_ry = 1'b0;
        issue(1'b1, 1'b0, 23'h7F0000, 8'h00);
        monitor(0, '0, '0, 100, 6, lat);
        chk("ry100.rise_seen", 32'(rise_k > 0), 32'd1);
        chk("ry100.done_after_rise", 32'(lat), 32'(rise_k + 1));
        chk("ry100.pulses", 32'(p_n), 32'd6);
        chk("ry100.last", {1'b0, p_addr[5], p_data[5]}, {1'b0, 23'h7F0000, 8'h30});
        after_done("ry100", 1'b0, 23'h7F0000);
        fl_ry = 1'b1;

        // Erase and write together: erase wins; write held through the busy period
        wait_idle();
        issue(1'b1, 1'b1, 23'h00F00F, 8'h11);
        monitor(1, 23'h123456, 8'hC3, -1, 0, lat);
        chk("both.latency", 32'(lat), 32'd46);
        check_pulses("both", 6,
                     {23'h00F00F, 23'h000555, 23'h000AAA, 23'h000AAA, 23'h000555, 23'h000AAA},
                     {8'h30, 8'h55, 8'hAA, 8'h80, 8'h55, 8'hAA});
        after_done("both", 1'b0, 23'h00F00F);
        monitor(0, '0, '0, -1, 0, lat);
        chk("held.latency", 32'(lat), 32'd34);
        check_pulses("held", 4,
                     {23'h0, 23'h0, 23'h123456, 23'h000AAA, 23'h000555, 23'h000AAA},
                     {8'h00, 8'h00, 8'hC3, 8'hA0, 8'h55, 8'hAA});
        after_done("held", 1'b0, 23'h123456);

        // Timeout (short-timeout instance), then error cleared by the next request
        wait_idle();
        sel_to = 1;
        fl_ry_to = 1'b0;
        issue(1'b0, 1'b1, 23'h000ABC, 8'h3C);
        monitor(0, '0, '0, -1, 0, lat);
        chk("tmo.latency", 32'(lat), 32'd83);
        chk("tmo.pulses", 32'(p_n), 32'd4);
        after_done("tmo", 1'b1, 23'h000ABC);
        fl_ry_to = 1'b1;
        wait_idle();
        issue(1'b0, 1'b1, 23'h000001, 8'h01);
        monitor(0, '0, '0, -1, 0, lat);
        chk("clr.err_first_cycle", 32'(k1_err), 32'd0);
        chk("clr.latency", 32'(lat), 32'd34);
        after_done("clr", 1'b0, 23'h000001);
        sel_to = 0;

        // Reset during WE_LOW of the second bus cycle
        wait_idle();
        issue(1'b0, 1'b1, 23'h0000AB, 8'h12);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            AVL_WRITE = 1'b0;
            if (m_we_n === 1'b0 && m_addr === 23'h000555) begin found = 1; break; end
        end
        chk("abort.reached_cycle2", 32'(found), 32'd1);
        #1 RESET = 1'b0;
        #1;
        chk("abort.we_n", 32'(m_we_n), 32'd1);
        chk("abort.ce_n", 32'(m_ce_n), 32'd1);
        chk("abort.reset_n", 32'(m_rst_n), 32'd0);
        chk("abort.dq_oe_wait", {30'd0, m_oe, m_wait}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        we_lows = 0; wait_highs = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (m_we_n !== 1'b1) we_lows++;
            if (m_wait !== 1'b0) wait_highs++;
        end
        chk("abort.no_more_we", 32'(we_lows), 32'd0);
        chk("abort.stays_idle", 32'(wait_highs), 32'd0);
        chk("abort.addr_cleared", 32'(m_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
